// File: rtl/vec_uop_sequencer.sv
// vec_uop_sequencer: splits one vector instruction into LANES-wide uops, tracks lane writebacks, stalls the scalar pipe
// Ports:
//   clk, rst                      clock, async active-high reset
//   instr_* / instr_ready         instruction handshake from ID (op, vd, vs1, vs2, vl)
//   flush                         abandon remaining uops, drain, finish without done
//   uop_* / uop_ready             uop handshake to the lanes (op, regs, elem_idx, mask)
//   wb_valid                      one lane writeback retired
//   busy, pipe_stall, done        status to the scalar pipeline
module vec_uop_sequencer #(
    parameter int MAX_VL = 8,
    parameter int LANES  = 2,
    parameter int OP_W   = 4,
    parameter int VL_W   = $clog2(MAX_VL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OP_W-1:0]  instr_op,
    input  logic [4:0]       instr_vd,
    input  logic [4:0]       instr_vs1,
    input  logic [4:0]       instr_vs2,
    input  logic [VL_W-1:0]  instr_vl,
    input  logic             flush,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [OP_W-1:0]  uop_op,
    output logic [4:0]       uop_vd,
    output logic [4:0]       uop_vs1,
    output logic [4:0]       uop_vs2,
    output logic [VL_W-1:0]  uop_elem_idx,
    output logic [LANES-1:0] uop_mask,
    input  logic             wb_valid,
    output logic             busy,
    output logic             pipe_stall,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [VL_W:0] STEP = (VL_W + 1)'(LANES);
    state_t          state, state_nxt;
    logic [VL_W-1:0] vl_q, outstanding, out_nxt;
    logic [VL_W:0]   idx_nxt;
    logic            flushed, accept, xfer, wb_dec, last;
    assign accept      = state == IDLE && instr_valid && !flush;
    assign uop_valid   = state == ISSUE;
    assign xfer        = uop_valid && uop_ready;
    assign wb_dec      = wb_valid && outstanding != '0;
    assign out_nxt     = outstanding + VL_W'(xfer) - VL_W'(wb_dec);
    assign idx_nxt     = {1'b0, uop_elem_idx} + STEP;
    assign last        = idx_nxt >= {1'b0, vl_q};
    assign instr_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign pipe_stall  = busy || (instr_valid && state == IDLE && instr_vl != '0);
    // a flushed instruction still passes through DONE but must not report completion
    assign done        = state == DONE && !flushed;
    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_mask
            assign uop_mask[i] = {1'b0, uop_elem_idx} + (VL_W + 1)'(i) < {1'b0, vl_q};
        end
    endgenerate
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (instr_vl == '0 ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nxt = (flush || (xfer && last)) ? DRAIN : ISSUE;
            // out_nxt already includes a writeback landing this cycle
            DRAIN:   state_nxt = out_nxt == '0 ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            uop_op       <= '0;
            uop_vd       <= '0;
            uop_vs1      <= '0;
            uop_vs2      <= '0;
            vl_q         <= '0;
            uop_elem_idx <= '0;
            outstanding  <= '0;
            flushed      <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (accept) begin
                uop_op       <= instr_op;
                uop_vd       <= instr_vd;
                uop_vs1      <= instr_vs1;
                uop_vs2      <= instr_vs2;
                vl_q         <= instr_vl;
                uop_elem_idx <= '0;
                flushed      <= 1'b0;
            end
            if (xfer) uop_elem_idx <= idx_nxt[VL_W-1:0];
            if (flush && (state == ISSUE || state == DRAIN)) flushed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vec_uop_sequencer.sv
// tb_vec_uop_sequencer: directed table and sequence checks for vec_uop_sequencer
module tb_vec_uop_sequencer;
    logic       clk = 0, rst = 1;
    logic       instr_valid = 0, instr_ready, flush = 0;
    logic [3:0] instr_op = 0, instr_vl = 0;
    logic [4:0] instr_vd = 0, instr_vs1 = 0, instr_vs2 = 0;
    logic       uop_valid, uop_ready = 0, wb_valid = 0;
    logic [3:0] uop_op, uop_elem_idx;
    logic [4:0] uop_vd, uop_vs1, uop_vs2;
    logic [1:0] uop_mask;
    logic       busy, pipe_stall, done;
    int         checks = 0, errors = 0;
    typedef struct {
        logic       iv;
        logic [3:0] vl;
        logic       ur, wb, fl, uv;
        logic [3:0] idx;
        logic [1:0] mask;
        logic       busy, stall, done, ir;
    } vec_t;
    vec_t tbl[16];
    vec_uop_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
        .instr_vl(instr_vl), .flush(flush), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_op(uop_op), .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
        .uop_elem_idx(uop_elem_idx), .uop_mask(uop_mask), .wb_valid(wb_valid),
        .busy(busy), .pipe_stall(pipe_stall), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input logic iv, input logic [3:0] vl, input logic ur, input logic wb,
                                input logic fl, input logic uv, input logic [3:0] idx, input logic [1:0] mask,
                                input logic b, input logic st, input logic d, input logic ir);
        vec_t v;
        v.iv = iv; v.vl = vl; v.ur = ur; v.wb = wb; v.fl = fl; v.uv = uv; v.idx = idx;
        v.mask = mask; v.busy = b; v.stall = st; v.done = d; v.ir = ir;
        return v;
    endfunction
    initial begin
        int  n_x, n_busy, n_done;
        logic prev;
        //            iv vl ur wb fl | uv idx mask busy stall done ir
        tbl[0]  = mk(1, 5, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1);
        tbl[1]  = mk(0, 0, 1, 0, 0,   1, 0, 3, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,   1, 2, 3, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0,   1, 2, 3, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,   1, 4, 1, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0,   1, 4, 1, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 0,   0, 6, 0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0,   0, 6, 0, 1, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0,   0, 6, 0, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,   0, 6, 0, 1, 1, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 0,   0, 6, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 0, 0,   0, 6, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 2, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_uv", int'(uop_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stall", int'(pipe_stall), 0);
        chk("rst_mask", int'(uop_mask), 0);
        chk("rst_op", int'(uop_op), 0);
        rst = 0;
        instr_op = 4'h5; instr_vd = 5'd3; instr_vs1 = 5'd7; instr_vs2 = 5'd9;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            instr_valid = tbl[k].iv; instr_vl = tbl[k].vl; uop_ready = tbl[k].ur;
            wb_valid = tbl[k].wb; flush = tbl[k].fl;
            #1;
            chk($sformatf("t%0d_uv", k), int'(uop_valid), int'(tbl[k].uv));
            chk($sformatf("t%0d_idx", k), int'(uop_elem_idx), int'(tbl[k].idx));
            chk($sformatf("t%0d_mask", k), int'(uop_mask), int'(tbl[k].mask));
            chk($sformatf("t%0d_busy", k), int'(busy), int'(tbl[k].busy));
            chk($sformatf("t%0d_stall", k), int'(pipe_stall), int'(tbl[k].stall));
            chk($sformatf("t%0d_done", k), int'(done), int'(tbl[k].done));
            chk($sformatf("t%0d_ready", k), int'(instr_ready), int'(tbl[k].ir));
        end
        // full-length instruction, writeback one cycle after each transfer
        @(negedge clk);
        instr_valid = 1; instr_vl = 8; instr_op = 4'hA; instr_vd = 5'd1; instr_vs1 = 5'd2; instr_vs2 = 5'd3;
        uop_ready = 1; wb_valid = 0; flush = 0;
        @(negedge clk);
        instr_valid = 0;
        prev = 0; n_x = 0; n_busy = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            wb_valid = prev;
            #1;
            if (busy) n_busy++;
            if (done) n_done++;
            if (uop_valid && uop_ready) begin
                if (n_x == 0) begin
                    chk("a_op", int'(uop_op), 10);
                    chk("a_vd", int'(uop_vd), 1);
                    chk("a_vs2", int'(uop_vs2), 3);
                end
                chk($sformatf("a_idx%0d", n_x), int'(uop_elem_idx), 2 * n_x);
                chk($sformatf("a_mask%0d", n_x), int'(uop_mask), 3);
                n_x++;
            end
            prev = uop_valid && uop_ready;
            @(negedge clk);
        end
        wb_valid = 0;
        chk("a_xfers", n_x, 4);
        chk("a_busy_cycles", n_busy, 6);
        chk("a_done_pulses", n_done, 1);
        // flush after two transfers with both writebacks outstanding
        instr_valid = 1; instr_vl = 8; uop_ready = 1;
        @(negedge clk);
        instr_valid = 0;
        #1 chk("b_uv0", int'(uop_valid), 1);
        @(negedge clk);
        @(negedge clk);
        uop_ready = 0; flush = 1;
        #1 chk("b_idx", int'(uop_elem_idx), 4);
        @(negedge clk);
        uop_ready = 1;
        #1 chk("b_drain_uv", int'(uop_valid), 0);
        chk("b_drain_busy", int'(busy), 1);
        @(negedge clk);
        flush = 0; wb_valid = 1;
        #1 chk("b_wb1_uv", int'(uop_valid), 0);
        chk("b_wb1_done", int'(done), 0);
        @(negedge clk);
        #1 chk("b_wb2_busy", int'(busy), 1);
        @(negedge clk);
        wb_valid = 0;
        #1 chk("b_fin_busy", int'(busy), 1);
        chk("b_fin_done", int'(done), 0);
        chk("b_fin_uv", int'(uop_valid), 0);
        @(negedge clk);
        #1 chk("b_idle_busy", int'(busy), 0);
        chk("b_idle_ready", int'(instr_ready), 1);
        // asynchronous reset in the middle of issue
        @(negedge clk);
        instr_valid = 1; instr_vl = 8; uop_ready = 1;
        @(negedge clk);
        instr_valid = 0;
        @(negedge clk);
        #2 rst = 1;
        #1 chk("c_rst_busy", int'(busy), 0);
        chk("c_rst_uv", int'(uop_valid), 0);
        chk("c_rst_ready", int'(instr_ready), 1);
        chk("c_rst_idx", int'(uop_elem_idx), 0);
        #1 rst = 0;
        @(negedge clk);
        wb_valid = 1;
        #1 chk("c_spur_busy", int'(busy), 0);
        @(negedge clk);
        wb_valid = 0; instr_valid = 1; instr_vl = 2;
        @(negedge clk);
        instr_valid = 0;
        #1 chk("c_uv", int'(uop_valid), 1);
        chk("c_mask", int'(uop_mask), 3);
        @(negedge clk);
        wb_valid = 1;
        #1 chk("c_drain_uv", int'(uop_valid), 0);
        chk("c_drain_busy", int'(busy), 1);
        @(negedge clk);
        wb_valid = 0;
        #1 chk("c_done", int'(done), 1);
        @(negedge clk);
        #1 chk("c_idle", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_uop_sequencer.md
Name: vec_uop_sequencer

Overview:
- Sequences one vector instruction at a time from the ID stage into element-group micro-ops (uops) for the vector lane datapath.
- Applies lane backpressure and tracks outstanding lane writebacks.
- Stalls the scalar pipeline while a vector instruction is in flight.
- Sits between decode and the vector lanes, inside top.

Parameters:
- MAX_VL, 8, maximum vector length in elements; power of two, ≥ LANES.
- LANES, 2, elements processed per uop; power of two.
- OP_W, 4, vector opcode width.
- VL_W, $clog2(MAX_VL+1), width of the vl field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- instr_valid  in  1  vector instruction offered by ID.
- instr_ready  out  1  sequencer accepts the instruction.
- instr_op  in  OP_W  vector opcode.
- instr_vd / instr_vs1 / instr_vs2  in  5 each  vector register addresses.
- instr_vl  in  VL_W  element count, 0..MAX_VL.
- flush  in  1  pipeline flush from branch/exception.
- uop_valid  out  1  uop presented to the lanes.
- uop_ready  in  1  lanes accept the uop.
- uop_op  out  OP_W  latched opcode.
- uop_vd / uop_vs1 / uop_vs2  out  5 each  latched register addresses.
- uop_elem_idx  out  VL_W  first element index of the group.
- uop_mask  out  LANES  active-lane mask; bit i set when elem_idx+i < vl.
- wb_valid  in  1  lanes retire one uop writeback.
- busy  out  1  state != IDLE.
- pipe_stall  out  1  stall the scalar IF/ID stages.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst=1) outputs:
  - state=IDLE, instr_ready=1, uop_valid=0, busy=0, pipe_stall=0, done=0.
  - All latched fields, elem_idx, mask and outstanding count = 0.
- IDLE:
  - instr_ready=1.
  - On instr_valid & ~flush: latch op/vd/vs1/vs2/vl, set elem_idx=0.
  - If vl=0, go to DONE; otherwise go to ISSUE.
  - flush in IDLE: instr ignored, no state change.
- ISSUE:
  - uop_valid=1 with the current elem_idx and mask.
  - A transfer occurs on uop_valid & uop_ready: elem_idx += LANES and outstanding++.
  - If elem_idx+LANES ≥ vl, the transfer is the last uop and the next state is DRAIN.
  - uop fields hold stable while uop_valid=1 & ~uop_ready.
- DRAIN: uop_valid=0. When outstanding=0 (including a wb that decrements it to 0 this cycle), go to DONE next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. Back-to-back acceptance happens the cycle after DONE.
- Outstanding counter:
  - Width VL_W.
  - +1 per uop transfer, −1 per wb_valid; simultaneous transfer and wb leaves it unchanged.
  - wb_valid with outstanding=0 is ignored (no underflow).
- Flush:
  - In ISSUE or DRAIN: go to DRAIN and stop issuing.
  - A uop transferring in the same cycle as flush still counts as issued.
  - Completion after a flush returns DONE→IDLE with done suppressed (0).
  - A second flush during DRAIN has no further effect.
- instr_ready = (state==IDLE).
- pipe_stall = busy | (instr_valid & state==IDLE & instr_vl!=0). This stalls the same cycle a nonzero-vl instruction is accepted.
- Mask on the last group: lanes at elem_idx+i ≥ vl are 0; all other groups are all-ones.
- Reset mid-operation: immediate return to reset values; outstanding writebacks are discarded.

Test Plan:
- Reset with rst=1 mid-ISSUE, async between edges -> busy=0, uop_valid=0, instr_ready=1 immediately.
- vl=8, LANES=2, uop_ready=1, wb_valid one cycle after each transfer -> 4 uops with elem_idx 0,2,4,6 and mask 2'b11; done pulses once; busy held 6 cycles.
- vl=5, uop_ready toggling 1,0,1,... -> uops at elem_idx 0,2,4 with last mask 2'b01; fields stable during stalled cycles; exactly 3 transfers.
- vl=0 -> instr accepted, no uop_valid, DONE pulse on the cycle after acceptance, then IDLE.
- vl=8, flush after the 2nd transfer with 2 wb outstanding -> no further uops; done stays 0; IDLE after the 2 wb_valid pulses.
- Transfer and wb_valid in the same cycle, plus a spurious wb_valid in IDLE -> outstanding count unchanged; no underflow; no spurious done.
